// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller.
package fnd_pkg;
    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } state_e;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int SAT_MAX = 9999;
    localparam int NUM_DIGITS = 4;
endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Value handshake and digit-drive bundle of fnd_scan_ctrl.
interface fnd_scan_ctrl_if #(
    parameter int VALUE_W = 14
);
    logic [VALUE_W-1:0] i_value;
    logic               i_valid;
    logic               o_ready;
    logic [1:0]         o_digitSelect;
    logic [3:0]         o_value;
    logic               o_overflow;

    modport master (
        output i_value, i_valid,
        input  o_ready, o_digitSelect,
        input  o_value, o_overflow
    );

    modport slave (
        input  i_value, i_valid,
        output o_ready, o_digitSelect,
        output o_value, o_overflow
    );
endinterface

// File: rtl/dd_add3.sv
// Double-dabble correction: add 3 to every BCD nibble >= 5.
module dd_add3
    import fnd_pkg::*;
(
    input  logic [15:0] bcd_i,
    output logic [15:0] bcd_o
);
    always_comb begin
        bcd_o = bcd_i;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (bcd_i[4*n +: 4] >= 4'd5)
                bcd_o[4*n +: 4] = bcd_i[4*n +: 4] + 4'd3;
        end
    end
endmodule

// File: rtl/fnd_scan_ctrl.sv
// Binary-to-BCD converter with multiplexed 4-digit FND scan.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_LEAD = 1
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    fnd_scan_ctrl_if.slave  bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(VALUE_W);
    localparam int BW = 4 * NUM_DIGITS;

    state_e             state_q, state_d;
    logic [VALUE_W-1:0] sh_q, sh_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [BW-1:0]      disp_q, disp_d;
    logic [BW-1:0]      add3;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [PW-1:0]      presc_q;
    logic [1:0]         dsel_q;
    logic               tick;
    logic               xfer;

    dd_add3 u_add3 (
        .bcd_i (bcd_q),
        .bcd_o (add3)
    );

    assign tick = (presc_q == PW'(SCAN_DIV - 1));
    assign xfer = bus.i_valid && (state_q == IDLE);

    // Scan runs free of the FSM
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            dsel_q  <= '0;
        end else if (tick) begin
            presc_q <= '0;
            dsel_q  <= dsel_q + 2'd1;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (32'(bus.i_value) > SAT_MAX) begin
                        sh_d  = VALUE_W'(SAT_MAX);
                        ovf_d = 1'b1;
                    end else begin
                        sh_d  = bus.i_value;
                        ovf_d = 1'b0;
                    end
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = (add3 << 1) | BW'(sh_q[VALUE_W-1]);
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(VALUE_W - 1))
                    state_d = UPDATE;
            end
            UPDATE: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [BW-1:0] upper;
    logic [3:0]    digit;
    logic          blank;

    // A slot is blank when it and every slot above it hold zero
    always_comb begin
        upper = disp_q >> {dsel_q, 2'b00};
        digit = disp_q[{dsel_q, 2'b00} +: 4];
        blank = (BLANK_LEAD != 0) && (dsel_q != 2'd0)
                && (upper == '0);
    end

    assign bus.o_ready       = (state_q == IDLE);
    assign bus.o_digitSelect = dsel_q;
    assign bus.o_value       = blank ? BLANK_CODE : digit;
    assign bus.o_overflow    = ovf_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl: three instances share one stimulus
// (A: blanking, B: no blanking, C: SCAN_DIV = 1).
module tb_fnd_scan_ctrl;
    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        valid;
    int          k;
    int          n_chk;
    int          n_err;

    fnd_scan_ctrl_if #(.VALUE_W(14)) ifa ();
    fnd_scan_ctrl_if #(.VALUE_W(14)) ifb ();
    fnd_scan_ctrl_if #(.VALUE_W(14)) ifc ();

    assign ifa.i_value = value;
    assign ifa.i_valid = valid;
    assign ifb.i_value = value;
    assign ifb.i_valid = valid;
    assign ifc.i_value = value;
    assign ifc.i_valid = valid;

    fnd_scan_ctrl #(
        .VALUE_W(14), .SCAN_DIV(4), .BLANK_LEAD(1)
    ) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifa.slave)
    );

    fnd_scan_ctrl #(
        .VALUE_W(14), .SCAN_DIV(4), .BLANK_LEAD(0)
    ) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifb.slave)
    );

    fnd_scan_ctrl #(
        .VALUE_W(14), .SCAN_DIV(1), .BLANK_LEAD(1)
    ) dut_c (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release: drives the expected scan position
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string tag, input int obs,
                       input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, obs, exp_v);
        end
    endtask

    function automatic int nib(input logic [15:0] p,
                               input int s);
        return int'(p[s*4 +: 4]);
    endfunction

    task automatic scan(input logic [15:0] pa,
                        input logic [15:0] pb);
        int da;
        int dc;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            da = (k / 4) % 4;
            dc = k % 4;
            chk("dsel_a", int'(ifa.o_digitSelect), da);
            chk("val_a", int'(ifa.o_value), nib(pa, da));
            chk("dsel_b", int'(ifb.o_digitSelect), da);
            chk("val_b", int'(ifb.o_value), nib(pb, da));
            chk("dsel_c", int'(ifc.o_digitSelect), dc);
            chk("val_c", int'(ifc.o_value), nib(pa, dc));
        end
    endtask

    task automatic load(input int v, input logic [15:0] oldp,
                        input logic [15:0] newp,
                        input bit inject);
        @(negedge clk);
        value = 14'(v);
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("rdy_lo", int'(ifa.o_ready), 0);
            if (inject && i == 3) begin
                value = 14'd42;
                valid = 1'b1;
            end
            if (inject && i == 7)
                valid = 1'b0;
            if (i == 14)
                chk("pre_upd", int'(ifa.o_value),
                    nib(oldp, (k / 4) % 4));
        end
        @(negedge clk);
        chk("rdy_hi", int'(ifa.o_ready), 1);
        chk("rdy_hi_c", int'(ifc.o_ready), 1);
        chk("post_upd", int'(ifa.o_value),
            nib(newp, (k / 4) % 4));
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_rdy"}, int'(ifa.o_ready), 1);
        chk({tag, "_ovf"}, int'(ifa.o_overflow), 0);
        chk({tag, "_dsel"}, int'(ifa.o_digitSelect), 0);
        chk({tag, "_val"}, int'(ifa.o_value), 0);
        chk({tag, "_val_b"}, int'(ifb.o_value), 0);
        chk({tag, "_val_c"}, int'(ifc.o_value), 0);
        chk({tag, "_ovf_c"}, int'(ifc.o_overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        valid = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        reset_vals("rst");
        rst_n = 1'b1;
        scan(16'hFFF0, 16'h0000);

        load(1234, 16'hFFF0, 16'h1234, 1'b0);
        chk("ovf_1234", int'(ifa.o_overflow), 0);
        scan(16'h1234, 16'h1234);

        load(12000, 16'h1234, 16'h9999, 1'b0);
        chk("ovf_12000", int'(ifa.o_overflow), 1);
        chk("ovf_12000_b", int'(ifb.o_overflow), 1);
        scan(16'h9999, 16'h9999);

        @(negedge clk);
        for (int i = 0; i < 4 && (k % 4) != 3; i++)
            @(negedge clk);
        chk("tick_align", k % 4, 3);
        value = 14'd9876;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        chk("tick_rdy", int'(ifa.o_ready), 0);
        chk("tick_dsel", int'(ifa.o_digitSelect), (k / 4) % 4);
        repeat (5) @(negedge clk);
        chk("conv_rdy", int'(ifa.o_ready), 0);
        rst_n = 1'b0;
        #1;
        reset_vals("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_rdy", int'(ifa.o_ready), 1);
        scan(16'hFFF0, 16'h0000);

        load(5, 16'hFFF0, 16'hFFF5, 1'b0);
        chk("ovf_5", int'(ifa.o_overflow), 0);
        scan(16'hFFF5, 16'h0005);

        load(1005, 16'hFFF5, 16'h1005, 1'b1);
        scan(16'h1005, 16'h1005);

        load(42, 16'h1005, 16'hFF42, 1'b0);
        scan(16'hFF42, 16'h0042);

        load(3210, 16'hFF42, 16'h3210, 1'b0);
        scan(16'h3210, 16'h3210);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
